// File: rtl/alu_exec_unit.sv
// alu_exec_unit: ALU execution unit with valid/ready handshakes, an iterative shift-add multiplier
// and an optional restoring divider (present only when ALU_EXEC_DIV_EN is defined).
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             div_zero,
  output logic [1:0]       dbg_state
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  localparam logic [2:0] OP_SUB   = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_MUL   = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_AND   = 3'b100;
  localparam logic [2:0] OP_SLL   = 3'b101;
  localparam logic [2:0] OP_OR    = 3'b110;
  localparam logic [2:0] OP_PASSB = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
`ifdef ALU_EXEC_DIV_EN
    , DIV = 2'd3
`endif
  } state_t;

  // Handshake: a request transfers on a rising edge with in_valid && in_ready (only in IDLE);
  // a result transfers with out_valid && out_ready (only in DONE), and the outputs hold
  // steady until then. A new request can be taken no earlier than the cycle after that.

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             div_zero_q, div_zero_d;

  function automatic logic [3:0] nzcv(input logic [WIDTH-1:0] r, input logic c, input logic v);
    return {r[WIDTH-1], (r == '0), c, v};
  endfunction

  // Single-cycle operations, evaluated straight from the request inputs at acceptance.
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;

  assign add_full = {1'b0, a} + {1'b0, b};
  assign sub_full = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (ALUControl)
      OP_SUB: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_c   = sub_full[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
      end
      OP_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
      end
      OP_MUL:   alu_res = '0;
      OP_DIV:   alu_res = '0;
      OP_AND:   alu_res = a & b;
      OP_SLL:   alu_res = a << b[SHW-1:0];
      OP_OR:    alu_res = a | b;
      OP_PASSB: alu_res = b;
      default:  alu_res = '0;
    endcase
  end

  // Multiplier step: add the shifted multiplicand when the current multiplier bit is set.
  logic [WIDTH-1:0] mul_acc;
  assign mul_acc = acc_q + (b_q[0] ? a_q : '0);

`ifdef ALU_EXEC_DIV_EN
  // Restoring divider step: acc_q is the partial remainder, a_q shifts the dividend out
  // from the top while quotient bits shift in at the bottom.
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] quo_next;

  assign div_sh   = {acc_q, a_q[WIDTH-1]};
  assign div_ge   = (div_sh >= {1'b0, b_q});
  assign div_rem  = div_ge ? WIDTH'(div_sh - {1'b0, b_q}) : div_sh[WIDTH-1:0];
  assign quo_next = {a_q[WIDTH-2:0], div_ge};
`endif

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    flags_d    = flags_q;
    div_zero_d = div_zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d   = a;
          b_d   = b;
          acc_d = '0;
          cnt_d = '0;
          if (ALUControl == OP_MUL) begin
            state_d = MUL;
          end
`ifdef ALU_EXEC_DIV_EN
          else if (ALUControl == OP_DIV && b != '0) begin
            state_d = DIV;
          end else if (ALUControl == OP_DIV) begin
            state_d    = DONE;
            result_d   = '1;
            flags_d    = nzcv('1, 1'b0, 1'b0);
            div_zero_d = 1'b1;
          end
`endif
          else begin
            state_d    = DONE;
            result_d   = alu_res;
            flags_d    = nzcv(alu_res, alu_c, alu_v);
            div_zero_d = 1'b0;
          end
        end
      end
      MUL: begin
        acc_d = mul_acc;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d    = DONE;
          result_d   = mul_acc;
          flags_d    = nzcv(mul_acc, 1'b0, 1'b0);
          div_zero_d = 1'b0;
        end
      end
`ifdef ALU_EXEC_DIV_EN
      DIV: begin
        acc_d = div_rem;
        a_d   = quo_next;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d    = DONE;
          result_d   = quo_next;
          flags_d    = nzcv(quo_next, 1'b0, 1'b0);
          div_zero_d = 1'b0;
        end
      end
`endif
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      flags_q    <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign flags     = flags_q;
  assign div_zero  = div_zero_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed checks of alu_exec_unit (WIDTH=32) for latency, results,
// flags, output hold under back-pressure and reset abort; divide vectors follow ALU_EXEC_DIV_EN.
module tb_alu_exec_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   alu_control = 3'b000;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic         div_zero;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // Clock / reset
  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUControl (alu_control),
    .a          (a_in),
    .b          (b_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .flags      (flags),
    .div_zero   (div_zero),
    .dbg_state  (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Driver: issue one request, scramble inputs after acceptance, wait for the result.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input int exp_lat, input logic [W-1:0] exp_res, input logic [3:0] exp_flags,
                        input logic exp_dz, input string tag);
    int lat;
    logic [W-1:0] exp_r;
    exp_q.push_back(exp_res);
    @(negedge clk);
    in_valid    = 1'b1;
    alu_control = op;
    a_in        = av;
    b_in        = bv;
    check({tag, " in_ready"}, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    a_in        = $urandom;
    b_in        = $urandom;
    alu_control = 3'($urandom_range(0, 7));
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    exp_r = exp_q.pop_front();
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " result"}, result, exp_r);
    check({tag, " flags"}, flags, exp_flags);
    check({tag, " div_zero"}, div_zero, exp_dz);
    if (out_ready) begin
      @(posedge clk);
      #1;
      check({tag, " back to idle"}, in_ready, 1);
    end
  endtask

  initial begin
    bit seen;

    repeat (2) @(posedge clk);
    #1;
    check("reset result", result, 0);
    check("reset flags", flags, 0);
    check("reset div_zero", div_zero, 0);
    check("reset out_valid", out_valid, 0);
    check("reset in_ready", in_ready, 1);
    check("reset state", dbg_state, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op(3'b001, 32'h7FFF_FFFF, 32'h1,         1, 32'h8000_0000, 4'b1001, 1'b0, "add ovf");
    run_op(3'b000, 32'd5,         32'd5,         1, 32'h0,         4'b0110, 1'b0, "sub 5-5");
    run_op(3'b000, 32'd0,         32'd1,         1, 32'hFFFF_FFFF, 4'b1000, 1'b0, "sub 0-1");
    run_op(3'b001, 32'hFFFF_FFFF, 32'h1,         1, 32'h0,         4'b0110, 1'b0, "add carry");
    run_op(3'b000, 32'h8000_0000, 32'h1,         1, 32'h7FFF_FFFF, 4'b0011, 1'b0, "sub ovf");
    run_op(3'b100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1, 32'h00F0_00F0, 4'b0000, 1'b0, "and");
    run_op(3'b110, 32'h8000_0000, 32'h1,         1, 32'h8000_0001, 4'b1000, 1'b0, "or");
    run_op(3'b101, 32'h1,         32'h23,        1, 32'h8,         4'b0000, 1'b0, "sll upper ign");
    run_op(3'b101, 32'h3,         32'd31,        1, 32'h8000_0000, 4'b1000, 1'b0, "sll 31");
    run_op(3'b111, 32'd123,       32'h0,         1, 32'h0,         4'b0100, 1'b0, "pass b");
    run_op(3'b010, 32'h1_0000,    32'h1_0001,    33, 32'h0001_0000, 4'b0000, 1'b0, "mul spec");
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'h1,        4'b0000, 1'b0, "mul max");
    run_op(3'b010, 32'd7,         32'd6,         33, 32'd42,       4'b0000, 1'b0, "mul 7x6");

`ifdef ALU_EXEC_DIV_EN
    run_op(3'b011, 32'd100,       32'd7,         33, 32'd14,        4'b0000, 1'b0, "div 100/7");
    run_op(3'b011, 32'd9,         32'd0,         1,  32'hFFFF_FFFF, 4'b1000, 1'b1, "div by zero");
    run_op(3'b001, 32'd1,         32'd1,         1,  32'd2,         4'b0000, 1'b0, "add after div0");
    run_op(3'b011, 32'hFFFF_FFFF, 32'd1,         33, 32'hFFFF_FFFF, 4'b1000, 1'b0, "div by one");
    run_op(3'b011, 32'd5,         32'd9,         33, 32'd0,         4'b0100, 1'b0, "div 5/9");
`else
    run_op(3'b011, 32'd100,       32'd7,         1,  32'h0,         4'b0100, 1'b0, "div disabled");
    run_op(3'b011, 32'd9,         32'd0,         1,  32'h0,         4'b0100, 1'b0, "div0 disabled");
`endif

    // Back-pressure: result must hold while out_ready is low
    out_ready = 1'b0;
    run_op(3'b001, 32'd2, 32'd3, 1, 32'd5, 4'b0000, 1'b0, "stall add");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("stall result", result, 5);
      check("stall flags", flags, 0);
      check("stall out_valid", out_valid, 1);
      check("stall in_ready", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release out_valid", out_valid, 0);
    check("release in_ready", in_ready, 1);

    // Reset in cycle 10 of a multiply
    @(negedge clk);
    in_valid    = 1'b1;
    alu_control = 3'b010;
    a_in        = 32'd1234;
    b_in        = 32'd5678;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort result", result, 0);
    check("abort flags", flags, 0);
    check("abort div_zero", div_zero, 0);
    check("abort out_valid", out_valid, 0);
    check("abort in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort no out_valid", seen, 0);
    run_op(3'b001, 32'd2, 32'd3, 1, 32'd5, 4'b0000, 1'b0, "add after abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
